feature_argmax_sink: RTL and testbench
======================================

// Module: feature_argmax_sink
// PURPOSE
//  Terminal consumer of a feature_if stream: accepts one VECTOR_LENGTH-beat frame of scores.
//  Tracks the running signed maximum and presents the winning class index on a valid/ready result port.
//  Sits after the final dense layer (relu=0) and turns the logit stream into the MNIST digit decision.
// PARAMETERS
//  VECTOR_LENGTH   10  beats per frame (number of classes); must be >= 2
//  TIMEOUT_CYCLES  0   max idle cycles between beats inside a frame before abort; 0 = timeout disabled
// PORTS
//  clock          input   1                  rising-edge clock
//  reset_n        input   1                  reset, asynchronous, active-low
//  features_in    feature_if (sink)          uses valid (in), ready (out), features[0] (in, feature_type, signed)
//  result_valid   output  1                  class_index/class_score hold a completed frame result
//  result_ready   input   1                  downstream accepts result
//  class_index    output  $clog2(VECTOR_LENGTH)  index of maximum score in the frame
//  class_score    output  feature_type       maximum score value
//  frame_error    output  1                  one-cycle pulse: frame aborted by timeout
//  frame_count    output  16                 completed frames (result handshakes), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state S_IDLE; beat_cnt=0; result_valid=0; class_index=0; class_score=0; frame_error=0; frame_count=0.
//  Beat = features_in.valid && features_in.ready at a rising edge.
//  features_in.ready = (state != S_RESULT); combinational from state only, never from valid.
//  FSM:
//   S_IDLE   : beat -> capture as running max (idx 0), beat_cnt=1, go S_RECV
//   S_RECV   : beat -> compare, beat_cnt++; beat with beat_cnt==VECTOR_LENGTH-1 -> go S_RESULT
//              idle_cnt reaches TIMEOUT_CYCLES (when nonzero) -> pulse frame_error, clear counters, go S_IDLE
//   S_RESULT : result_valid=1, outputs stable; result_ready -> frame_count++, go S_IDLE
//  Compare: signed, strict greater-than; ties keep the lower index; first beat is loaded unconditionally.
//  Latency: result_valid rises on the cycle after the last beat is accepted.
//   Final-beat compare result is registered directly into class_index/class_score (no extra cycle).
//  idle_cnt: cleared on every beat and in S_IDLE; increments each S_RECV cycle without a beat.
//   Saturates at TIMEOUT_CYCLES.
//  Boundaries:
//   - valid with ready low (S_RESULT): not a beat; upstream must hold it. Accepted first cycle after return to S_IDLE.
//   - result_ready high in same cycle result_valid rises: handshake completes that edge; ready high next cycle.
//   - result_ready may be high while result_valid low: no effect.
//   - frame_count 0xFFFF + handshake -> 0x0000.
//   - timeout and beat on same edge: beat wins, no error.
//   - reset_n low mid-frame: partial frame discarded immediately; all outputs to reset values asynchronously.
//  Width: class_score is feature_type unchanged; no arithmetic beyond compare, no saturation needed.
// STRUCTURE
//  mnist_pkg additions: typedef enum logic [1:0] {S_IDLE,S_RECV,S_RESULT} argmax_state_t;
//   localparam NUM_CLASSES=10; feature_type reused as-is.
//  One sub-module: stall_timer (parameter LIMIT; inputs clear, enable; output expired).
//   Shared with other stream blocks needing timeouts; LIMIT=0 ties expired low.
//  Remaining compare/FSM logic stays inline.
// TESTING
//  1 Frame scores {3,-7,12,5,0,12,1,2,-1,4}, result_ready=1 -> class_index=2, class_score=12, frame_count=1.
//    Tie at index 5 must not win.
//  2 All scores negative {-9,-3,-8,...,-20} -> index 1, score -3. Checks signed compare.
//  3 Hold result_ready=0 for 20 cycles after frame; upstream valid=1 -> ready stays 0.
//    Outputs stable; release -> next frame starts cleanly.
//  4 Random valid gaps (0-5 cycles) with TIMEOUT_CYCLES=0 -> same result as gapless frame.
//  5 TIMEOUT_CYCLES=8: send 4 beats then stall 8 cycles -> single frame_error pulse, no result_valid.
//    Next full frame is correct.
//  6 Assert reset_n mid-frame after beat 6 -> outputs at reset values; following full frame yields correct argmax.
//    Also preload frame_count=0xFFFF via 65535 frames or force -> wraps to 0.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared types for the MNIST inference pipeline: feature word, class count and
// the argmax sink state encoding.
package mnist_pkg;

    localparam int FEATURE_WIDTH = 16;
    localparam int NUM_CLASSES   = 10;

    typedef logic signed [FEATURE_WIDTH-1:0] feature_type;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_RESULT
    } argmax_state_t;

    // Strictly greater keeps the earlier index on ties.
    function automatic logic score_beats(input feature_type candidate, input feature_type current);
        return candidate > current;
    endfunction

endpackage

// File: rtl/feature_if.sv
// Valid/ready stream of feature words between pipeline stages.
interface feature_if #(
    parameter int NUM_FEATURES = 1
);
    logic                     valid;
    logic                     ready;
    mnist_pkg::feature_type   features [NUM_FEATURES];

    modport source (output valid, output features, input ready);
    modport sink   (input valid, input features, output ready);
endinterface

// File: rtl/feature_argmax_sink_stall_timer.sv
// Saturating idle counter for stream blocks; expired stays high once LIMIT idle
// cycles have been counted. LIMIT=0 disables the timer entirely.
module stall_timer #(
    parameter int LIMIT = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (LIMIT == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = ^{clock, reset_n, clear, enable};
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam int CW = $clog2(LIMIT + 1);
            localparam logic [CW-1:0] LIMIT_VAL = CW'(LIMIT);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clear) begin
                    count_d = '0;
                end else if (enable && (count_q != LIMIT_VAL)) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired = (count_q == LIMIT_VAL);
        end
    endgenerate

endmodule

// File: rtl/feature_argmax_sink.sv
// Terminal stream consumer: takes one VECTOR_LENGTH-beat frame of signed scores and
// presents the index/value of the maximum on a valid/ready result port.
module feature_argmax_sink
    import mnist_pkg::*;
#(
    parameter int VECTOR_LENGTH  = NUM_CLASSES,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                              clock,
    input  logic                              reset_n,
    feature_if.sink                           features_in,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic [$clog2(VECTOR_LENGTH)-1:0]  class_index,
    output feature_type                       class_score,
    output logic                              frame_error,
    output logic [15:0]                       frame_count
);

    localparam int IDX_W = $clog2(VECTOR_LENGTH);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(VECTOR_LENGTH - 1);

    argmax_state_t     state_q, state_d;
    logic [IDX_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]  run_index_q, run_index_d;
    feature_type       run_score_q, run_score_d;
    logic [IDX_W-1:0]  class_index_q, class_index_d;
    feature_type       class_score_q, class_score_d;
    logic              result_valid_q, result_valid_d;
    logic              frame_error_q, frame_error_d;
    logic [15:0]       frame_count_q, frame_count_d;

    logic              in_ready;
    logic              beat;
    feature_type       beat_score;
    logic              take_new;
    logic [IDX_W-1:0]  cmp_index;
    feature_type       cmp_score;
    logic              timer_clear;
    logic              timer_enable;
    logic              timer_expired;

    // Ready depends on state only so upstream never sees a valid->ready loop.
    assign in_ready          = (state_q != S_RESULT);
    assign features_in.ready = in_ready;
    assign beat              = features_in.valid && in_ready;
    assign beat_score        = features_in.features[0];

    assign take_new  = score_beats(beat_score, run_score_q);
    assign cmp_index = take_new ? beat_cnt_q : run_index_q;
    assign cmp_score = take_new ? beat_score : run_score_q;

    assign timer_clear  = beat || (state_q != S_RECV);
    assign timer_enable = (state_q == S_RECV);

    stall_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        run_index_d    = run_index_q;
        run_score_d    = run_score_q;
        class_index_d  = class_index_q;
        class_score_d  = class_score_q;
        result_valid_d = result_valid_q;
        frame_error_d  = 1'b0;
        frame_count_d  = frame_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (beat) begin
                    run_index_d = '0;
                    run_score_d = beat_score;
                    beat_cnt_d  = IDX_W'(1);
                    state_d     = S_RECV;
                end
            end
            S_RECV: begin
                // A beat on the expiry edge takes priority over the abort.
                if (beat) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        class_index_d  = cmp_index;
                        class_score_d  = cmp_score;
                        result_valid_d = 1'b1;
                        beat_cnt_d     = '0;
                        state_d        = S_RESULT;
                    end else begin
                        run_index_d = cmp_index;
                        run_score_d = cmp_score;
                        beat_cnt_d  = beat_cnt_q + 1'b1;
                    end
                end else if (timer_expired) begin
                    frame_error_d = 1'b1;
                    beat_cnt_d    = '0;
                    state_d       = S_IDLE;
                end
            end
            S_RESULT: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    frame_count_d  = frame_count_q + 16'd1;
                    state_d        = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            beat_cnt_q     <= '0;
            run_index_q    <= '0;
            run_score_q    <= '0;
            class_index_q  <= '0;
            class_score_q  <= '0;
            result_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            run_index_q    <= run_index_d;
            run_score_q    <= run_score_d;
            class_index_q  <= class_index_d;
            class_score_q  <= class_score_d;
            result_valid_q <= result_valid_d;
            frame_error_q  <= frame_error_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign result_valid = result_valid_q;
    assign class_index  = class_index_q;
    assign class_score  = class_score_q;
    assign frame_error  = frame_error_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_feature_argmax_sink.sv
// Directed bench for feature_argmax_sink: dut_a has an 8-cycle timeout, dut_b has it disabled.
module tb_feature_argmax_sink;
    import mnist_pkg::*;

    localparam int VL = NUM_CLASSES;
    localparam int IW = $clog2(VL);

    typedef feature_type frame_t [VL];
    typedef int gap_t [VL];
    typedef struct packed {
        logic [IW-1:0] idx;
        feature_type   score;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    feature_if fi_a ();
    feature_if fi_b ();

    logic          rr_a, rr_b, rv_a, rv_b, fe_a, fe_b;
    logic [IW-1:0] ci_a, ci_b;
    feature_type   cs_a, cs_b;
    logic [15:0]   fc_a, fc_b;

    feature_argmax_sink #(.VECTOR_LENGTH(VL), .TIMEOUT_CYCLES(8)) dut_a (
        .clock        (clock),
        .reset_n      (reset_n),
        .features_in  (fi_a),
        .result_valid (rv_a),
        .result_ready (rr_a),
        .class_index  (ci_a),
        .class_score  (cs_a),
        .frame_error  (fe_a),
        .frame_count  (fc_a)
    );

    feature_argmax_sink #(.VECTOR_LENGTH(VL), .TIMEOUT_CYCLES(0)) dut_b (
        .clock        (clock),
        .reset_n      (reset_n),
        .features_in  (fi_b),
        .result_valid (rv_b),
        .result_ready (rr_b),
        .class_index  (ci_b),
        .class_score  (cs_b),
        .frame_error  (fe_b),
        .frame_count  (fc_b)
    );

    int checks = 0;
    int errors = 0;
    exp_t exp_q_a [$];
    exp_t exp_q_b [$];
    logic [15:0] fc_exp_a = '0;
    logic [15:0] fc_exp_b = '0;

    // Pulse counters sampled on the clock edge (pre-update values).
    int fe_cnt_a = 0, fe_cnt_b = 0, rv_cnt_a = 0;
    always @(posedge clock) begin
        fe_cnt_a <= fe_cnt_a + (fe_a ? 1 : 0);
        fe_cnt_b <= fe_cnt_b + (fe_b ? 1 : 0);
        rv_cnt_a <= rv_cnt_a + (rv_a ? 1 : 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input feature_type f);
        if (sel == 0) begin
            fi_a.valid = v;
            fi_a.features[0] = f;
        end else begin
            fi_b.valid = v;
            fi_b.features[0] = f;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? fi_a.ready : fi_b.ready;
    endfunction

    function automatic exp_t ref_argmax(input frame_t s);
        exp_t e;
        feature_type best;
        e.idx = '0;
        best = s[0];
        for (int i = 1; i < VL; i++) begin
            if (s[i] > best) begin
                best = s[i];
                e.idx = IW'(i);
            end
        end
        e.score = best;
        return e;
    endfunction

    task automatic send_beat(input int sel, input feature_type v, input int gap);
        int n;
        if (gap > 0) begin
            drive(sel, 1'b0, '0);
            repeat (gap) step();
        end
        drive(sel, 1'b1, v);
        n = 0;
        while (!rdy(sel) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("ready_wait", 32'(rdy(sel)), 32'd1);
        step();
    endtask

    task automatic send_frame(input int sel, input frame_t s, input gap_t g);
        exp_t e;
        e = ref_argmax(s);
        if (sel == 0) exp_q_a.push_back(e);
        else exp_q_b.push_back(e);
        for (int i = 0; i < VL; i++) send_beat(sel, s[i], g[i]);
        drive(sel, 1'b0, '0);
    endtask

    // Called on the cycle right after the last beat: result must already be valid.
    task automatic expect_result(input int sel);
        exp_t e;
        logic rv;
        logic [IW-1:0] ci;
        feature_type cs;
        if (sel == 0) begin rv = rv_a; ci = ci_a; cs = cs_a; end
        else begin rv = rv_b; ci = ci_b; cs = cs_b; end
        check("result_valid_latency", 32'(rv), 32'd1);
        if ((sel == 0 && exp_q_a.size() == 0) || (sel == 1 && exp_q_b.size() == 0)) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        if (sel == 0) e = exp_q_a.pop_front();
        else e = exp_q_b.pop_front();
        check("class_index", 32'(ci), 32'(e.idx));
        check("class_score", 32'(cs), 32'(e.score));
        $display("frame dut%0d: class_index=%0d class_score=%0d (expected %0d/%0d)",
                 sel, ci, cs, e.idx, e.score);
    endtask

    // Called one edge after result_ready was high with result_valid high.
    task automatic expect_handshake(input int sel);
        if (sel == 0) begin
            fc_exp_a = fc_exp_a + 16'd1;
            check("handshake_rv_low", 32'(rv_a), 32'd0);
            check("frame_count", 32'(fc_a), 32'(fc_exp_a));
            check("ready_after", 32'(fi_a.ready), 32'd1);
        end else begin
            fc_exp_b = fc_exp_b + 16'd1;
            check("handshake_rv_low", 32'(rv_b), 32'd0);
            check("frame_count", 32'(fc_b), 32'(fc_exp_b));
            check("ready_after", 32'(fi_b.ready), 32'd1);
        end
    endtask

    initial begin
        frame_t f;
        gap_t   g0, g;
        exp_t   held;
        int     fe0, rv0;

        for (int i = 0; i < VL; i++) g0[i] = 0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        rr_a = 1'b0;
        rr_b = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Reset state
        check("rst_result_valid", 32'(rv_a), 32'd0);
        check("rst_class_index", 32'(ci_a), 32'd0);
        check("rst_class_score", 32'(cs_a), 32'd0);
        check("rst_frame_error", 32'(fe_a), 32'd0);
        check("rst_frame_count", 32'(fc_a), 32'd0);
        check("rst_ready", 32'(fi_a.ready), 32'd1);
        check("rst_b_result_valid", 32'(rv_b), 32'd0);

        // 1: tie at index 5 must not beat index 2; ready high as result rises
        rr_a = 1'b1;
        f = '{3, -7, 12, 5, 0, 12, 1, 2, -1, 4};
        send_frame(0, f, g0);
        expect_result(0);
        check("t1_index_const", 32'(ci_a), 32'd2);
        step();
        expect_handshake(0);
        step();
        check("rr_high_no_rv_effect", 32'(fc_a), 32'(fc_exp_a));

        // 2: all negative, signed compare
        f = '{-9, -3, -8, -10, -11, -12, -13, -14, -15, -20};
        send_frame(0, f, g0);
        expect_result(0);
        step();
        expect_handshake(0);

        // 3: back-pressure for 20 cycles with upstream valid held
        rr_a = 1'b0;
        f = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 50};
        held = ref_argmax(f);
        send_frame(0, f, g0);
        expect_result(0);
        drive(0, 1'b1, 16'sd77);
        for (int c = 0; c < 20; c++) begin
            step();
            check("hold_ready_low", 32'(fi_a.ready), 32'd0);
            check("hold_rv", 32'(rv_a), 32'd1);
            check("hold_index", 32'(ci_a), 32'(held.idx));
            check("hold_score", 32'(cs_a), 32'(held.score));
        end
        rr_a = 1'b1;
        step();
        expect_handshake(0);
        f = '{77, -5, 80, 80, 3, 0, 0, 0, 0, 79};
        send_frame(0, f, g0);
        expect_result(0);
        step();
        expect_handshake(0);

        // 4: gapless vs gapped on disabled-timeout DUT, including one long stall
        rr_b = 1'b1;
        f = '{3, -7, 12, 5, 0, 12, 1, 2, -1, 4};
        send_frame(1, f, g0);
        expect_result(1);
        step();
        expect_handshake(1);
        for (int i = 0; i < VL; i++) g[i] = int'($urandom_range(5, 0));
        g[4] = 30;
        send_frame(1, f, g);
        expect_result(1);
        step();
        expect_handshake(1);
        check("b_no_frame_error", 32'(fe_cnt_b), 32'd0);

        // Gapped frame on the timeout DUT; a 7-cycle gap stays under the limit
        fe0 = fe_cnt_a;
        for (int i = 0; i < VL; i++) g[i] = int'($urandom_range(5, 0));
        g[5] = 7;
        f = '{-4, 6, 2, 6, 11, -30, 10, 11, 0, 1};
        send_frame(0, f, g);
        expect_result(0);
        step();
        expect_handshake(0);
        check("a_gap_no_error", 32'(fe_cnt_a - fe0), 32'd0);

        // 5: 4 beats then stall -> exactly one frame_error, no result
        fe0 = fe_cnt_a;
        rv0 = rv_cnt_a;
        for (int i = 0; i < 4; i++) send_beat(0, feature_type'(i + 5), 0);
        drive(0, 1'b0, '0);
        repeat (15) step();
        check("timeout_pulse_count", 32'(fe_cnt_a - fe0), 32'd1);
        check("timeout_no_result", 32'(rv_cnt_a - rv0), 32'd0);
        check("timeout_ready", 32'(fi_a.ready), 32'd1);
        check("timeout_frame_count", 32'(fc_a), 32'(fc_exp_a));
        f = '{0, 1, -1, 2, 2, 9, 9, -30, 9, 3};
        send_frame(0, f, g0);
        expect_result(0);
        step();
        expect_handshake(0);

        // 6: asynchronous reset after beat 6
        for (int i = 0; i < 6; i++) send_beat(0, feature_type'(20 + i), 0);
        reset_n = 1'b0;
        #2;
        check("async_rst_rv", 32'(rv_a), 32'd0);
        check("async_rst_index", 32'(ci_a), 32'd0);
        check("async_rst_score", 32'(cs_a), 32'd0);
        check("async_rst_fe", 32'(fe_a), 32'd0);
        check("async_rst_fc", 32'(fc_a), 32'd0);
        fc_exp_a = '0;
        fc_exp_b = '0;
        drive(0, 1'b0, '0);
        step();
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_ready", 32'(fi_a.ready), 32'd1);
        f = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        send_frame(0, f, g0);
        expect_result(0);
        step();
        expect_handshake(0);

        // frame_count wrap 0xFFFF -> 0
        force dut_a.frame_count_q = 16'hFFFF;
        #1;
        release dut_a.frame_count_q;
        fc_exp_a = 16'hFFFF;
        f = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        send_frame(0, f, g0);
        expect_result(0);
        step();
        expect_handshake(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
